adder_seq: RTL and testbench

ADDER_SEQ -- requirements
Module: adder_seq

---
 rtl/adder_seq.sv | 133 +++++++++++++
 tb/tb_adder_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: adds SLICE bits per cycle over WIDTH/SLICE cycles.
// Optional macro ADDER_SEQ_SUB_EN builds subtraction; otherwise 'sub' is ignored.
module adder_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [KW-1:0]    r_k;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin0;
  logic [SLICE:0]   w_slice;
  logic             w_last;

`ifdef ADDER_SEQ_SUB_EN
  // Subtract as a + ~b + 1; cin has no meaning for a subtraction.
  assign w_b_eff = sub ? ~b : b;
  assign w_cin0  = sub ? 1'b1 : cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_eff      = b;
  assign w_cin0       = cin;
`endif

  assign w_last  = (r_k == K_LAST);
  assign w_slice = {1'b0, r_a[int'(r_k)*SLICE +: SLICE]}
                 + {1'b0, r_b[int'(r_k)*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, r_carry};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = BUSY;
        else          w_state_nxt = IDLE;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
        else        w_state_nxt = BUSY;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
        else           w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch on accept, then one slice per BUSY cycle; flags are taken from the top slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin0;
            r_k     <= '0;
          end
        end
        BUSY: begin
          r_sum[int'(r_k)*SLICE +: SLICE] <= w_slice[SLICE-1:0];
          r_carry                         <= w_slice[SLICE];
          if (w_last) begin
            r_cout <= w_slice[SLICE];
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_slice[SLICE-1] != r_a[WIDTH-1]);
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: vector table, handshake/reset corners, random vs. arithmetic model.
module tb_adder_seq;

`ifdef ADDER_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        t_in_valid;
  logic        t_in_ready;
  logic [31:0] t_a;
  logic [31:0] t_b;
  logic        t_cin;
  logic        t_sub;
  logic        t_out_valid;
  logic        t_out_ready;
  logic [31:0] t_sum;
  logic        t_cout;
  logic        t_ovf;

  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_a;
  logic [15:0] h_b;
  logic        h_cin;
  logic        h_sub;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [15:0] h_sum;
  logic        h_cout;
  logic        h_ovf;

  int n_tests;
  int n_fail;

  adder_seq #(.WIDTH(32), .SLICE(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .a(t_a), .b(t_b), .cin(t_cin), .sub(t_sub),
    .out_valid(t_out_valid), .out_ready(t_out_ready),
    .sum(t_sum), .cout(t_cout), .ovf(t_ovf)
  );

  adder_seq #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .cin(h_cin), .sub(h_sub),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .sum(h_sum), .cout(h_cout), .ovf(h_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                                input logic ms, output logic [31:0] es, output logic eco,
                                output logic eov);
    longint sa;
    longint sb;
    longint sr;
    logic [63:0] full;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (ms && SUB_EN) begin
      full = {32'd0, ma} - {32'd0, mb};
      es   = full[31:0];
      eco  = (ma >= mb);
      sr   = sa - sb;
    end else begin
      full = {32'd0, ma} + {32'd0, mb} + {63'd0, mc};
      es   = full[31:0];
      eco  = full[32];
      sr   = sa + sb + longint'(mc);
    end
    eov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  task automatic run_op(input logic [31:0] ra, input logic [31:0] rb, input logic rc,
                        input logic rs, input logic [31:0] es, input logic eco,
                        input logic eov, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, {63'd0, t_in_ready}, 64'd1);
    t_a = ra; t_b = rb; t_cin = rc; t_sub = rs; t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'($urandom_range(0, 1));
    t_a = $urandom; t_b = $urandom; t_cin = 1'($urandom_range(0, 1)); t_sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!t_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    t_in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd2);
    chk({tag, "_sum"}, {32'd0, t_sum}, {32'd0, es});
    chk({tag, "_cout"}, {63'd0, t_cout}, {63'd0, eco});
    chk({tag, "_ovf"}, {63'd0, t_ovf}, {63'd0, eov});
    @(posedge clk); #1;
    chk({tag, "_back_idle"}, {62'd0, t_out_valid, t_in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, es;
    logic rc, rs, eco, eov;
    int lat;
    n_tests = 0;
    n_fail  = 0;

    vt[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[4] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
    vt[5] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
`ifdef ADDER_SEQ_SUB_EN
    vt[6] = '{32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[7] = '{32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
`else
    vt[6] = '{32'd5, 32'd7, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0};
    vt[7] = '{32'd7, 32'd5, 1'b1, 1'b1, 32'h0000000D, 1'b0, 1'b0};
`endif

    rst_n = 1'b0;
    t_in_valid = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0; t_sub = 1'b0; t_out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_cin = 1'b0; h_sub = 1'b0; h_out_ready = 1'b1;
    #1;
    chk("reset_outputs", {t_sum, 29'd0, t_cout, t_ovf, t_out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, t_in_ready}, 64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].s, vt[i].co, vt[i].ov,
             $sformatf("vec%0d", i));

    // Consumer stall: result must hold and new requests must be ignored.
    t_out_ready = 1'b0;
    @(negedge clk);
    t_a = 32'h7FFFFFFF; t_b = 32'h00000001; t_cin = 1'b0; t_sub = 1'b0; t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    lat = 0;
    while (!t_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      t_in_valid = 1'b1; t_a = $urandom; t_b = $urandom;
      @(posedge clk); #1;
      chk("stall_sum", {32'd0, t_sum}, 64'h80000000);
      chk("stall_flags", {60'd0, t_cout, t_ovf, t_in_ready, t_out_valid}, 64'h5);
    end
    @(negedge clk);
    t_in_valid = 1'b0; t_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {62'd0, t_out_valid, t_in_ready}, 64'd1);

    // Reset one cycle into BUSY aborts the operation.
    @(negedge clk);
    t_a = 32'h00001234; t_b = 32'h00000001; t_cin = 1'b0; t_sub = 1'b0; t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {t_sum, 29'd0, t_cout, t_ovf, t_out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, t_in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", {63'd0, t_out_valid}, 64'd0);
    end
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, "post_reset");

    // Single-slice build: one BUSY cycle.
    @(negedge clk);
    h_a = 16'h8000; h_b = 16'h8000; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 0;
    while (!h_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_latency", 64'(lat), 64'd1);
    chk("w16_result", {46'd0, h_sum, h_cout, h_ovf}, {46'd0, 16'h0000, 1'b1, 1'b1});
    @(posedge clk); #1;
    chk("w16_back_idle", {62'd0, h_out_valid, h_in_ready}, 64'd1);

    for (int i = 0; i < 40; i++) begin
      case (i % 8)
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) == 0);
      model(ra, rb, rc, rs, es, eco, eov);
      run_op(ra, rb, rc, rs, es, eco, eov, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
